// File: rtl/mic_wake_ctrl.sv
// Sound-triggered wake controller: synchronises and debounces the mic comparator,
// pulses signal_awake once per alert and drives a beep pattern on the buzzer.
module mic_wake_ctrl #(
  parameter int TICKS_ON       = 50000000,
  parameter int TICKS_OFF      = 50000000,
  parameter int N_BEEPS        = 4,
  parameter int DEBOUNCE_TICKS = 50000,
  parameter int COOLDOWN_TICKS = 100000000,
  parameter int CNT_W          = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mic,
  input  logic       enable,
  input  logic       mute,
  input  logic       mode,
  input  logic       ack,
  output logic       buzzer,
  output logic       signal_awake,
  output logic       busy,
  output logic [7:0] wake_count
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_QUAL  = 2'd1;
  localparam logic [1:0] S_ALERT = 2'd2;
  localparam logic [1:0] S_COOL  = 2'd3;

  localparam int BW = $clog2(N_BEEPS + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(TICKS_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(TICKS_OFF - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_TICKS - 1);
  localparam logic [BW-1:0]    BEEP_LAST = BW'(N_BEEPS - 1);
  localparam logic [BW-1:0]    BEEP_MAX  = BW'(N_BEEPS);

  logic             sync1, mic_s, mic_p, rise;
  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BW-1:0]    beep, beep_n;
  logic             phase_on, phase_on_n;
  logic             mode_l, mode_l_n;
  logic             wake_inc;

  assign rise = mic_s & ~mic_p;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    beep_n     = beep;
    phase_on_n = phase_on;
    mode_l_n   = mode_l;
    wake_inc   = 1'b0;
    case (state)
      S_IDLE: if (rise) begin
        state_n = S_QUAL;
        cnt_n   = '0;
      end
      S_QUAL: begin
        if (!mic_s) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n    = S_ALERT;
          wake_inc   = 1'b1;
          mode_l_n   = mode;
          beep_n     = '0;
          cnt_n      = '0;
          phase_on_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_ALERT: begin
        if (ack) begin
          state_n = S_COOL;
          cnt_n   = '0;
        end else if (phase_on) begin
          if (cnt == ON_LAST) begin
            phase_on_n = 1'b0;
            cnt_n      = '0;
          end else cnt_n = cnt + CNT_W'(1);
        end else if (cnt == OFF_LAST) begin
          // End of a full beep: either finish the fixed pattern or start the next ON.
          cnt_n      = '0;
          phase_on_n = 1'b1;
          beep_n     = (beep == BEEP_MAX) ? beep : beep + BW'(1);
          if (!mode_l && beep == BEEP_LAST) state_n = S_COOL;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        if (cnt == COOL_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + CNT_W'(1);
      end
    endcase
    if (!enable) begin
      state_n    = S_IDLE;
      cnt_n      = '0;
      beep_n     = '0;
      phase_on_n = 1'b0;
      wake_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= 1'b0;
      mic_s        <= 1'b0;
      mic_p        <= 1'b0;
      state        <= S_IDLE;
      cnt          <= '0;
      beep         <= '0;
      phase_on     <= 1'b0;
      mode_l       <= 1'b0;
      buzzer       <= 1'b0;
      signal_awake <= 1'b0;
      busy         <= 1'b0;
      wake_count   <= 8'd0;
    end else begin
      sync1        <= mic;
      mic_s        <= sync1;
      mic_p        <= mic_s;
      state        <= state_n;
      cnt          <= cnt_n;
      beep         <= beep_n;
      phase_on     <= phase_on_n;
      mode_l       <= mode_l_n;
      // Outputs are derived from next state so they line up with the state register.
      buzzer       <= (state_n == S_ALERT) && phase_on_n && !mute;
      signal_awake <= wake_inc;
      busy         <= (state_n != S_IDLE);
      if (wake_inc && wake_count != 8'hFF) wake_count <= wake_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_mic_wake_ctrl.sv
// Bench for mic_wake_ctrl: directed timeline checks plus randomized traffic against
// a countdown-based behavioural model.
module tb_mic_wake_ctrl;
  localparam int T_ON = 4, T_OFF = 3, NB = 2, DEB = 3, COOL = 5;

  logic clk, rst, mic, enable, mute, mode, ack;
  logic buzzer, signal_awake, busy;
  logic [7:0] wake_count;

  mic_wake_ctrl #(.TICKS_ON(T_ON), .TICKS_OFF(T_OFF), .N_BEEPS(NB),
    .DEBOUNCE_TICKS(DEB), .COOLDOWN_TICKS(COOL), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mic(mic), .enable(enable), .mute(mute), .mode(mode),
    .ack(ack), .buzzer(buzzer), .signal_awake(signal_awake), .busy(busy),
    .wake_count(wake_count));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0, n_bad = 0, lbl = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: activity names plus "cycles remaining" countdowns.
  localparam int M_IDLE = 0, M_QUAL = 1, M_ALERT = 2, M_COOL = 3;
  int m_act = M_IDLE, m_left = 0, m_beeps = 0, m_wake = 0;
  bit m_on = 0, m_mode = 0, m_s1 = 0, m_s2 = 0, m_p = 0;
  bit e_buz = 0, e_awake = 0, e_busy = 0;

  task automatic model_edge();
    bit rise;
    rise = m_s2 && !m_p;
    e_awake = 0;
    if (rst) begin
      m_act = M_IDLE; m_left = 0; m_beeps = 0; m_wake = 0; m_on = 0;
      m_s1 = 0; m_s2 = 0; m_p = 0; e_buz = 0; e_busy = 0;
      return;
    end
    if (!enable) begin
      m_act = M_IDLE; m_left = 0; m_beeps = 0; m_on = 0;
    end else begin
      case (m_act)
        M_IDLE: if (rise) begin m_act = M_QUAL; m_left = DEB; end
        M_QUAL: begin
          if (!m_s2) m_act = M_IDLE;
          else begin
            m_left--;
            if (m_left == 0) begin
              m_act = M_ALERT; e_awake = 1; m_mode = mode; m_beeps = 0;
              m_on = 1; m_left = T_ON;
              if (m_wake < 255) m_wake++;
            end
          end
        end
        M_ALERT: begin
          if (ack) begin m_act = M_COOL; m_left = COOL; end
          else begin
            m_left--;
            if (m_left == 0) begin
              if (m_on) begin m_on = 0; m_left = T_OFF; end
              else begin
                m_beeps++;
                if (!m_mode && m_beeps == NB) begin m_act = M_COOL; m_left = COOL; end
                else begin m_on = 1; m_left = T_ON; end
              end
            end
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_act = M_IDLE;
        end
      endcase
    end
    e_buz  = (m_act == M_ALERT) && m_on && !mute;
    e_busy = (m_act != M_IDLE);
    m_p = m_s2; m_s2 = m_s1; m_s1 = mic;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("buzzer", buzzer, e_buz);
    chk("signal_awake", signal_awake, e_awake);
    chk("busy", busy, e_busy);
    chk("wake_count", wake_count, m_wake);
    lbl++;
  endtask

  task automatic run_to(input int n);
    while (lbl < n) step();
  endtask

  task automatic do_reset();
    rst = 1; mic = 0; enable = 1; mute = 0; mode = 0; ack = 0;
    step();
    rst = 0;
    chk("rst_buzzer", buzzer, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wake", wake_count, 0);
    lbl = 0;
  endtask

  initial begin
    int hold;
    bit saw_awake;

    // 1: basic mode-0 alert
    do_reset(); mic = 1;
    run_to(5);  chk("t1_awake5", signal_awake, 0);
    run_to(6);  chk("t1_awake6", signal_awake, 1); chk("t1_buz6", buzzer, 1);
    run_to(7);  chk("t1_awake7", signal_awake, 0);
    run_to(10); chk("t1_buz10", buzzer, 0);
    run_to(13); chk("t1_buz13", buzzer, 1);
    run_to(17); chk("t1_buz17", buzzer, 0);
    run_to(24); chk("t1_busy24", busy, 1);
    run_to(25); chk("t1_busy25", busy, 0); chk("t1_wake", wake_count, 1);
    run_to(35); chk("t1_noretrig", busy, 0);

    // 2: short glitch never qualifies
    do_reset(); mic = 1; saw_awake = 0;
    run_to(2); mic = 0;
    while (lbl < 15) begin step(); saw_awake |= signal_awake; end
    chk("t2_awake", saw_awake, 0); chk("t2_wake", wake_count, 0);

    // 3: mode 1 runs until ack
    do_reset(); mode = 1; mic = 1;
    run_to(30); chk("t3_buz30", buzzer, 1);
    ack = 1; step(); ack = 0;
    chk("t3_buz31", buzzer, 0); chk("t3_busy31", busy, 1);
    run_to(35); chk("t3_busy35", busy, 1);
    run_to(36); chk("t3_busy36", busy, 0);
    mode = 0;

    // 4: mute keeps the timing but silences the buzzer
    do_reset(); mute = 1; mic = 1;
    run_to(6);  chk("t4_awake6", signal_awake, 1); chk("t4_buz6", buzzer, 0);
    run_to(14); chk("t4_buz14", buzzer, 0);
    run_to(24); chk("t4_busy24", busy, 1);
    run_to(25); chk("t4_busy25", busy, 0);
    mute = 0;

    // 5: rise during cooldown is discarded; fresh rise in idle re-triggers
    do_reset(); mic = 1;
    run_to(20); mic = 0; step(); mic = 1;
    run_to(40); chk("t5_wake1", wake_count, 1); chk("t5_idle", busy, 0);
    mic = 0; run_to(45); mic = 1;
    run_to(60); chk("t5_wake2", wake_count, 2);

    // 6a: enable drop mid-beep
    do_reset(); mic = 1;
    run_to(8); chk("t6a_buz8", buzzer, 1);
    enable = 0; step();
    chk("t6a_buz9", buzzer, 0); chk("t6a_busy9", busy, 0); chk("t6a_wake", wake_count, 1);
    enable = 1; mic = 0; run_to(15);

    // 6b: reset mid-beep
    do_reset(); mic = 1;
    run_to(8); rst = 1; step(); rst = 0;
    chk("t6b_buz9", buzzer, 0); chk("t6b_busy9", busy, 0); chk("t6b_wake", wake_count, 0);

    // Randomized traffic against the model
    mic = 0; hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        mic  = $urandom_range(1, 0);
        hold = $urandom_range(12, 1);
      end
      hold--;
      enable = ($urandom_range(99, 0) >= 2);
      if ($urandom_range(19, 0) == 0) mute = ~mute;
      if ($urandom_range(49, 0) == 0) mode = ~mode;
      ack = ($urandom_range(99, 0) < 3);
      rst = ($urandom_range(999, 0) < 3);
      step();
    end
    rst = 0; ack = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mic_wake_ctrl.md
Name: mic_wake_ctrl

Overview:
Parametrised sound-triggered wake controller. It qualifies the microphone comparator output with synchronisation and debounce, then raises a one-cycle wake pulse and drives a buzzer with a programmable beep pattern. Two modes are supported: fixed beep count, and continuous beeping until acknowledged. After each alert it holds a cooldown and counts wake events. It sits between the mic sensor pin and the pet FSM, which consumes signal_awake.

Parameters:
TICKS_ON, 50000000, buzzer-high cycles per beep (>=1)
TICKS_OFF, 50000000, buzzer-low cycles per beep (>=1)
N_BEEPS, 4, beeps per alert in mode 0 (>=1)
DEBOUNCE_TICKS, 50000, consecutive high cycles of synced mic needed to qualify (>=1)
COOLDOWN_TICKS, 100000000, cycles mic is ignored after an alert (>=1)
CNT_W, 28, width of the shared phase counter; must hold max(TICKS_ON, TICKS_OFF, DEBOUNCE_TICKS, COOLDOWN_TICKS)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
mic  in  1  raw asynchronous mic comparator output
enable  in  1  block enabled; low forces IDLE
mute  in  1  forces buzzer low; timing and pattern continue unchanged
mode  in  1  0 = N_BEEPS then stop; 1 = beep until ack
ack  in  1  single-cycle acknowledge; ends an alert in either mode
buzzer  out  1  buzzer drive, registered
signal_awake  out  1  one-cycle pulse on the first cycle of ALERT
busy  out  1  high when state != IDLE
wake_count  out  8  number of alerts since reset, saturating at 255

Behaviour:
- Reset (synchronous, active-high) and its effect on outputs:
  - state=IDLE; counters, beep index and both sync flops = 0.
  - buzzer=0, signal_awake=0, busy=0, wake_count=0.
  - rst asserted mid-alert: buzzer is low the cycle after the reset edge.
- Input path:
  - mic passes a 2-flop synchroniser to produce mic_s.
  - mic_p holds the previous value of mic_s.
  - A rise is mic_s=1 while mic_p=0.
- States: IDLE, QUALIFY, ALERT, COOLDOWN.
- IDLE:
  - A rise with enable=1 moves to QUALIFY, with the counter cleared.
  - A level-high mic with no rise never triggers.
- QUALIFY:
  - Each cycle with mic_s=1, the counter increments.
  - mic_s=0 returns to IDLE.
  - The cycle with mic_s=1 and counter==DEBOUNCE_TICKS-1 moves to ALERT.
  - In the same cycle: wake_count increments (saturating), mode is latched, beep index and counter clear, phase=ON.
- Wake latency:
  - mic held high from sampling edge 0 gives ALERT (and signal_awake) on cycle DEBOUNCE_TICKS+3.
- ALERT:
  - signal_awake=1 for exactly its first cycle.
  - Phase ON: buzzer=~mute for TICKS_ON cycles.
  - Phase OFF: buzzer=0 for TICKS_OFF cycles.
  - At the end of each OFF phase the beep index increments.
  - Latched mode 0: after the N_BEEPS-th OFF phase, go to COOLDOWN.
  - Latched mode 1: wraps ON/OFF indefinitely; the beep index saturates.
  - The mic is ignored during ALERT.
- ack:
  - ack=1 in ALERT moves to COOLDOWN next cycle; buzzer is 0 from that cycle.
  - ack outside ALERT is ignored.
- COOLDOWN:
  - buzzer=0 for COOLDOWN_TICKS cycles, then IDLE.
  - A rise during COOLDOWN is discarded.
  - Re-trigger needs a new rise observed in IDLE.
- enable=0:
  - From any state, next state is IDLE, buzzer=0, counters cleared.
  - wake_count is held.
  - enable=0 and ack in the same cycle resolve to IDLE (enable wins).
- Runtime changes:
  - mute takes effect on buzzer the next cycle.
  - A mode change during ALERT has no effect until the next alert.
- busy is registered and equals (state != IDLE).

Test Plan:
Params for all tests: TICKS_ON=4, TICKS_OFF=3, N_BEEPS=2, DEBOUNCE_TICKS=3, COOLDOWN_TICKS=5.
1. Basic alert, mode 0, mic high from cycle 0 -> signal_awake pulse at cycle 6; buzzer high 6-9 and 13-16, low 10-12 and 17-19; COOLDOWN 20-24; busy=0 from 25; wake_count=1.
2. Glitch: mic high for 2 synced cycles, then low -> QUALIFY then IDLE; no signal_awake; wake_count=0.
3. Mode 1 with ack at cycle 30 -> buzzer keeps the 4/3 pattern through cycle 30, is 0 from 31; COOLDOWN 31-35; IDLE at 36.
4. mute=1 during alert -> buzzer stays 0; state timing identical to test 1; signal_awake still at cycle 6.
5. New mic rise during COOLDOWN, and mic held high across COOLDOWN->IDLE -> no second alert; a fresh low-to-high after IDLE triggers alert 2 and wake_count=2.
6. enable=0 at cycle 8 mid-beep, or rst at cycle 8 -> buzzer=0 and busy=0 from cycle 9; enable case keeps wake_count=1, rst case clears it to 0.
